// File: rtl/fir_core.sv
// fir_core: parallel NTAPS-tap unsigned FIR dot-product engine.
// Stage 1 registers one full-width product per tap. Stage 2 registers the
// sum of all products, formed by a balanced adder tree and wrapped to
// DWIDTH+CWIDTH bits.
//
// Flow control: there is no valid/ready pair. EN is a pure pipeline clock
// enable. Both stages advance together on every rising edge with EN=1 and
// hold otherwise. A window presented at enabled edge k is reflected on dout
// just after enabled edge k+1. Downstream logic counts enabled edges to know
// when dout carries a meaningful result.
module fir_core #(
  parameter int DWIDTH = 15,
  parameter int CWIDTH = 11,
  parameter int NTAPS  = 37
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [DWIDTH-1:0]        din   [NTAPS],
  input  logic [CWIDTH-1:0]        coeff [NTAPS],
  output logic [DWIDTH+CWIDTH-1:0] dout
);

  localparam int PW     = DWIDTH + CWIDTH;
  localparam int LEVELS = (NTAPS > 1) ? $clog2(NTAPS) : 0;

  // Stage-1 product registers, one per tap.
  logic [PW-1:0] p [NTAPS];

  // Capture din[i]*coeff[i] for every tap on each enabled edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) p[i] <= '0;
    end else if (EN) begin
      for (int i = 0; i < NTAPS; i++) p[i] <= PW'(din[i]) * PW'(coeff[i]);
    end
  end

  // Balanced adder tree. Level l holds ceil(NTAPS / 2^l) nodes; an odd node
  // at the end of a level passes straight through to the next level. Every
  // node is PW bits, so carries out of the top bit are dropped, which gives
  // the required modulo 2^PW wrap for free.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = (NTAPS + (1 << l) - 1) >> l;
    logic [PW-1:0] node [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_n
        assign node[i] = p[i];
      end
    end else begin : g_add
      localparam int NPREV = (NTAPS + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar i = 0; i < N; i++) begin : g_n
        if (2 * i + 1 < NPREV) begin : g_pair
          assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[2*i];
        end
      end
    end
  end

  logic [PW-1:0] sum;
  assign sum = g_lvl[LEVELS].node[0];

  // Stage-2 result register: latch the tree sum on each enabled edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout <= '0;
    end else if (EN) begin
      dout <= sum;
    end
  end

endmodule

// File: tb/tb_fir_core.sv
// tb_fir_core: randomized and directed bench for fir_core with a behavioural
// dot-product model and a per-cycle compare process.
module tb_fir_core;

  localparam int DW = 15;
  localparam int CW = 11;
  localparam int NT = 37;
  localparam int PW = DW + CW;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [DW-1:0] din   [NT];
  logic [CW-1:0] coeff [NT];
  logic [PW-1:0] dout;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: windows captured but not yet on dout.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_dout;

  int ctab [NT] = '{144,115,158,207,263,325,392,462,535,609,682,752,817,876,
                    926,968,998,1016,1023,1016,998,968,926,876,817,752,682,
                    609,535,462,392,325,263,207,158,115,144};

  fir_core #(.DWIDTH(DW), .CWIDTH(CW), .NTAPS(NT)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .din   (din),
    .coeff (coeff),
    .dout  (dout)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  // Plain dot product of the window currently on the inputs, mod 2^PW.
  function automatic logic [PW-1:0] dot_now();
    longint s;
    s = 0;
    for (int i = 0; i < NT; i++) s += longint'(din[i]) * longint'(coeff[i]);
    return PW'(s);
  endfunction

  // Each enabled edge captures one window; dout shows the window captured on
  // the previous enabled edge (reset leaves one zero result pending).
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      exp_q.push_back('0);
      exp_dout = '0;
    end else if (EN) begin
      exp_q.push_back(dot_now());
      exp_dout = exp_q.pop_front();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: dout=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge CLK) begin
    check("model", dout, exp_dout);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic rand_window();
    for (int i = 0; i < NT; i++) din[i] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic rand_coeff();
    for (int i = 0; i < NT; i++) coeff[i] = CW'($urandom_range(0, (1 << CW) - 1));
  endtask

  task automatic fill_din(input int v);
    for (int i = 0; i < NT; i++) din[i] = DW'(v);
  endtask

  task automatic load_ctab();
    for (int i = 0; i < NT; i++) coeff[i] = CW'(ctab[i]);
  endtask

  task automatic stream(input int cycles, input int en_pct);
    for (int c = 0; c < cycles; c++) begin
      rand_window();
      if ($urandom_range(0, 3) == 0) rand_coeff();
      EN = ($urandom_range(1, 100) <= en_pct);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    rand_window();
    rand_coeff();

    // Reset held with live inputs and EN=1: dout must stay 0.
    for (int c = 0; c < 5; c++) begin
      step();
      check("reset_hold", dout, '0);
      rand_window();
      rand_coeff();
    end

    // Impulse: release reset, idle two cycles, then enable.
    RST = 1'b0;
    EN  = 1'b0;
    load_ctab();
    fill_din(0);
    din[36] = DW'(1);
    step();
    step();
    EN = 1'b1;
    step();
    check("impulse_edge1", dout, '0);
    step();
    check("impulse_edge2", dout, PW'(144));
    step();
    check("impulse_edge3", dout, PW'(144));

    // DC window.
    fill_din(1);
    step();
    step();
    check("dc_window", dout, PW'(21513));

    // Enable stall with changing inputs: dout holds.
    EN = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_window();
      step();
      check("stall_hold", dout, PW'(21513));
    end
    EN = 1'b1;
    rand_window();
    step();
    check("stall_resume1", dout, PW'(21513));
    step();

    // Wrap-around with all-max operands.
    fill_din((1 << DW) - 1);
    for (int i = 0; i < NT; i++) coeff[i] = CW'((1 << CW) - 1);
    step();
    step();
    check("wrap", dout, PW'(65820709));

    // Streaming, always enabled.
    stream(150, 100);

    // Streaming with random enable gaps.
    stream(200, 70);

    // Asynchronous reset mid-cycle: dout clears before the next edge.
    EN = 1'b1;
    rand_window();
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", dout, '0);
    step();
    RST = 1'b0;
    rand_window();
    step();
    check("post_reset_edge1", dout, '0);

    // Behaviour after mid-run reset matches power-up.
    stream(200, 80);

    EN = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
